// File: rtl/hwpe_stream_fifo_sidech_arbiter.sv
// Round-robin, burst-locking arbiter sharing one side-channel FIFO push port
// between NB_IN stream requesters. The granted requester's beat is forwarded
// combinationally and its index is driven on sidech_o, so every beat popped
// from the downstream FIFO carries its source ID.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   clear_i          synchronous soft clear (beats every other update)
//   enable_i         allows new grants; in LOCKED it only forces release
//   push_i_*         NB_IN flattened requester streams (valid/data/strb in,
//                    ready out); requester k occupies slice k
//   push_o_*         stream towards the FIFO push port (ready in)
//   sidech_o         index of the granted requester, 0 when none
//   grant_o          one-hot current grant, 0 when none
//   busy_o           high while a burst is locked
module hwpe_stream_fifo_sidech_arbiter #(
  parameter int unsigned NB_IN      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_WIDTH   = $clog2(NB_IN),
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          enable_i,
  input  logic [NB_IN-1:0]              push_i_valid,
  input  logic [NB_IN*DATA_WIDTH-1:0]   push_i_data,
  input  logic [NB_IN*STRB_WIDTH-1:0]   push_i_strb,
  output logic [NB_IN-1:0]              push_i_ready,
  output logic                          push_o_valid,
  output logic [DATA_WIDTH-1:0]         push_o_data,
  output logic [STRB_WIDTH-1:0]         push_o_strb,
  input  logic                          push_o_ready,
  output logic [ID_WIDTH-1:0]           sidech_o,
  output logic [NB_IN-1:0]              grant_o,
  output logic                          busy_o
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e                r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_WIDTH-1:0]   r_lock_id, w_lock_id_nxt;
  logic [CNT_WIDTH-1:0]  r_beat_cnt, w_beat_cnt_nxt;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_win;
  logic                  w_gnt_valid;
  logic [ID_WIDTH-1:0]   w_gnt_idx;
  logic                  w_hs;
  logic                  w_release;

  logic [DATA_WIDTH-1:0] w_data_arr [NB_IN];
  logic [STRB_WIDTH-1:0] w_strb_arr [NB_IN];

  for (genvar k = 0; k < NB_IN; k++) begin : gen_unpack
    assign w_data_arr[k] = push_i_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_strb_arr[k] = push_i_strb[k*STRB_WIDTH +: STRB_WIDTH];
  end

  function automatic logic [ID_WIDTH-1:0] inc_id(input logic [ID_WIDTH-1:0] id);
    if (32'(id) == NB_IN - 1) return '0;
    return id + 1'b1;
  endfunction

  // First valid requester searching rr_ptr, rr_ptr+1, ... modulo NB_IN.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 0; i < NB_IN; i++) begin
      idx = 32'(r_rr_ptr) + i;
      if (idx >= NB_IN) idx = idx - NB_IN;
      if (!w_found && push_i_valid[ID_WIDTH'(idx)]) begin
        w_found = 1'b1;
        w_win   = ID_WIDTH'(idx);
      end
    end
  end

  // A locked grant ignores enable_i and the other requesters.
  assign w_gnt_valid = (r_state == StLocked) || (enable_i && w_found);
  assign w_gnt_idx   = (r_state == StLocked) ? r_lock_id : w_win;

  always_comb begin
    push_o_valid = 1'b0;
    push_o_data  = '0;
    push_o_strb  = '0;
    sidech_o     = '0;
    grant_o      = '0;
    push_i_ready = '0;
    if (w_gnt_valid) begin
      push_o_valid            = push_i_valid[w_gnt_idx];
      push_o_data             = w_data_arr[w_gnt_idx];
      push_o_strb             = w_strb_arr[w_gnt_idx];
      sidech_o                = w_gnt_idx;
      grant_o[w_gnt_idx]      = 1'b1;
      push_i_ready[w_gnt_idx] = push_o_ready;
    end
  end

  assign w_hs   = push_o_valid && push_o_ready;
  assign busy_o = (r_state == StLocked);

  // Dropping valid also covers the enable_i=0 without handshake case.
  assign w_release = (w_hs && (r_beat_cnt == CNT_WIDTH'(MAX_BURST - 1)))
                   || !push_i_valid[r_lock_id]
                   || (!enable_i && w_hs);

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_lock_id_nxt  = r_lock_id;
    w_beat_cnt_nxt = r_beat_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_valid) begin
          if (w_hs && (MAX_BURST == 1)) begin
            w_rr_ptr_nxt = inc_id(w_win);
          end else begin
            // A stalled offer also locks, keeping the beat stable until taken.
            w_state_nxt    = StLocked;
            w_lock_id_nxt  = w_win;
            w_beat_cnt_nxt = w_hs ? CNT_WIDTH'(1) : '0;
          end
        end
      end
      StLocked: begin
        if (w_hs) w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        if (w_release) begin
          w_state_nxt    = StIdle;
          w_rr_ptr_nxt   = inc_id(r_lock_id);
          w_beat_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_lock_id  <= '0;
      r_beat_cnt <= '0;
    end else if (clear_i) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_lock_id  <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_lock_id  <= w_lock_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

endmodule
